// File: rtl/hades_pkg.sv
// rtl/hades_pkg.sv - shared hades-V writeback types and constants
package hades_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_e;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_funct3_e;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - execute handshake and data-memory response bus into writeback
interface writeback_stage_if;
   import hades_pkg::*;

   logic                  ex_valid;
   logic                  ex_ready;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic [XLEN-1:0]       ex_result;
   logic                  ex_is_load;
   logic [2:0]            ex_funct3;
   logic                  mem_rvalid;
   logic [XLEN-1:0]       mem_rdata;

   modport master (
      output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, mem_rvalid, mem_rdata,
      input  ex_ready
   );

   modport slave (
      input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3, mem_rvalid, mem_rdata,
      output ex_ready
   );

endinterface

// File: rtl/load_extender.sv
// rtl/load_extender.sv - selects the addressed byte/half of a load word and extends it
module load_extender
   import hades_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Misaligned halves/words are not trapped here; only the lane-select bits matter.
   always_comb begin
      byte_sel = rdata[{addr, 3'b000} +: 8];
      half_sel = rdata[{addr[1], 4'b0000} +: 16];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LW:   result = rdata;
         F3_LBU:  result = {24'h000000, byte_sel};
         F3_LHU:  result = {16'h0000, half_sel};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final hades-V stage, sole register-file writer; WB_INSTRET_EN adds instret
module writeback_stage
   import hades_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   writeback_stage_if.slave      bus,
   output logic [REG_ADDR_W-1:0] rf_write_address,
   output logic [XLEN-1:0]       rf_write_data,
   output logic                  rf_write_enable,
   output logic                  wb_busy
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]           instret
`endif
);

   wb_state_e             state;
   wb_state_e             state_next;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [2:0]            funct3_q;
   logic [1:0]            addr_q;
   logic [XLEN-1:0]       load_data;
   logic                  retire;
   logic [REG_ADDR_W-1:0] retire_rd;
   logic [XLEN-1:0]       retire_data;

   load_extender u_load_extender (
      .rdata  (bus.mem_rdata),
      .addr   (addr_q),
      .funct3 (funct3_q),
      .result (load_data)
   );

   assign wb_busy = (state == WAIT_LOAD);

   always_comb begin
      state_next   = state;
      bus.ex_ready = 1'b0;
      retire       = 1'b0;
      retire_rd    = '0;
      retire_data  = '0;
      case (state)
         IDLE: begin
            bus.ex_ready = 1'b1;
            if (bus.ex_valid) begin
               if (bus.ex_is_load) begin
                  state_next = WAIT_LOAD;
               end else begin
                  retire      = 1'b1;
                  retire_rd   = bus.ex_rd;
                  retire_data = bus.ex_result;
               end
            end
         end
         WAIT_LOAD: begin
            if (bus.mem_rvalid) begin
               retire      = 1'b1;
               retire_rd   = rd_q;
               retire_data = load_data;
               state_next  = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         rd_q             <= '0;
         funct3_q         <= '0;
         addr_q           <= '0;
         rf_write_enable  <= 1'b0;
         rf_write_address <= '0;
         rf_write_data    <= '0;
      end else begin
         state           <= state_next;
         // x0 still retires, it just never reaches the register file.
         rf_write_enable <= retire && (retire_rd != '0);
         if (retire) begin
            rf_write_address <= retire_rd;
            rf_write_data    <= retire_data;
         end
         if (state == IDLE && bus.ex_valid && bus.ex_is_load) begin
            rd_q     <= bus.ex_rd;
            funct3_q <= bus.ex_funct3;
            addr_q   <= bus.ex_result[1:0];
         end
      end
   end

`ifdef WB_INSTRET_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + 64'd1;
      end
   end
`endif

endmodule
